// File: rtl/gat_bram_loader_if.sv
// rtl/gat_bram_loader_if.sv - Source word stream and three BRAM write ports of gat_bram_loader
interface gat_bram_loader_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int H_DATA_WIDTH     = 19,
  parameter int NODE_INFO_WIDTH  = 20,
  parameter int H_DATA_ADDR_W    = 18,
  parameter int NODE_INFO_ADDR_W = 14,
  parameter int WEIGHT_ADDR_W    = 15
);
  logic                          s_valid;
  logic [31:0]                   s_data;
  logic                          s_ready;

  logic [H_DATA_WIDTH-1:0]       h_data_bram_din;
  logic                          h_data_bram_ena;
  logic                          h_data_bram_wea;
  logic [H_DATA_ADDR_W+1:0]      h_data_bram_addra;

  logic [NODE_INFO_WIDTH-1:0]    h_node_info_bram_din;
  logic                          h_node_info_bram_ena;
  logic                          h_node_info_bram_wea;
  logic [NODE_INFO_ADDR_W+1:0]   h_node_info_bram_addra;

  logic [DATA_WIDTH-1:0]         wgt_bram_din;
  logic                          wgt_bram_ena;
  logic                          wgt_bram_wea;
  logic [WEIGHT_ADDR_W+1:0]      wgt_bram_addra;

  modport master (
    output s_valid, s_data,
    input  s_ready,
    input  h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    input  h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
    input  wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready,
    output h_data_bram_din, h_data_bram_ena, h_data_bram_wea, h_data_bram_addra,
    output h_node_info_bram_din, h_node_info_bram_ena, h_node_info_bram_wea, h_node_info_bram_addra,
    output wgt_bram_din, wgt_bram_ena, wgt_bram_wea, wgt_bram_addra
  );
endinterface

// File: rtl/gat_bram_loader.sv
// rtl/gat_bram_loader.sv - Loads H data, node info and weights from a word stream into three BRAMs
// Optional upper-bit format check enabled by defining GAT_LOADER_ERR_CHK_EN.
module gat_bram_loader #(
  parameter int DATA_WIDTH       = 8,
  parameter int H_DATA_WIDTH     = 19,
  parameter int NODE_INFO_WIDTH  = 20,
  parameter int H_DATA_ADDR_W    = 18,
  parameter int NODE_INFO_ADDR_W = 14,
  parameter int WEIGHT_ADDR_W    = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [H_DATA_ADDR_W:0]    h_data_cnt,
  input  logic [NODE_INFO_ADDR_W:0] h_node_info_cnt,
  input  logic [WEIGHT_ADDR_W:0]    wgt_cnt,
  gat_bram_loader_if.slave          bus,
  output logic                      h_data_bram_load_done,
  output logic                      h_node_info_bram_load_done,
  output logic                      wgt_bram_load_done,
  output logic                      busy,
  output logic                      err
);
  localparam int MAX_HN = (H_DATA_ADDR_W > NODE_INFO_ADDR_W) ? H_DATA_ADDR_W : NODE_INFO_ADDR_W;
  localparam int IDX_W  = (MAX_HN > WEIGHT_ADDR_W) ? MAX_HN : WEIGHT_ADDR_W;

  typedef enum logic [2:0] {IDLE, LD_HDATA, LD_NINFO, LD_WGT, DONE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [H_DATA_ADDR_W:0]    cnt_h;
  logic [NODE_INFO_ADDR_W:0] cnt_n;
  logic [WEIGHT_ADDR_W:0]    cnt_w;
  logic [IDX_W:0]            cur_cnt;
  logic                      accept;
  logic                      last;

  assign accept = bus.s_valid & bus.s_ready;

  always_comb begin
    cur_cnt = '0;
    case (state)
      LD_HDATA: cur_cnt = (IDX_W+1)'(cnt_h);
      LD_NINFO: cur_cnt = (IDX_W+1)'(cnt_n);
      LD_WGT:   cur_cnt = (IDX_W+1)'(cnt_w);
      default:  cur_cnt = '0;
    endcase
  end

  assign last = ((IDX_W+1)'(idx) + (IDX_W+1)'(1)) == cur_cnt;

  // A zero-count section spends one cycle in its state; a beat offered then is not written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      idx                        <= '0;
      cnt_h                      <= '0;
      cnt_n                      <= '0;
      cnt_w                      <= '0;
      busy                       <= 1'b0;
      bus.s_ready                <= 1'b0;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
      bus.h_data_bram_ena        <= 1'b0;
      bus.h_data_bram_wea        <= 1'b0;
      bus.h_data_bram_din        <= '0;
      bus.h_data_bram_addra      <= '0;
      bus.h_node_info_bram_ena   <= 1'b0;
      bus.h_node_info_bram_wea   <= 1'b0;
      bus.h_node_info_bram_din   <= '0;
      bus.h_node_info_bram_addra <= '0;
      bus.wgt_bram_ena           <= 1'b0;
      bus.wgt_bram_wea           <= 1'b0;
      bus.wgt_bram_din           <= '0;
      bus.wgt_bram_addra         <= '0;
    end else begin
      bus.h_data_bram_ena      <= 1'b0;
      bus.h_data_bram_wea      <= 1'b0;
      bus.h_node_info_bram_ena <= 1'b0;
      bus.h_node_info_bram_wea <= 1'b0;
      bus.wgt_bram_ena         <= 1'b0;
      bus.wgt_bram_wea         <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt_h                      <= h_data_cnt;
            cnt_n                      <= h_node_info_cnt;
            cnt_w                      <= wgt_cnt;
            idx                        <= '0;
            h_data_bram_load_done      <= 1'b0;
            h_node_info_bram_load_done <= 1'b0;
            wgt_bram_load_done         <= 1'b0;
            busy                       <= 1'b1;
            bus.s_ready                <= 1'b1;
            state                      <= LD_HDATA;
          end
        end
        LD_HDATA: begin
          if (accept && cnt_h != '0) begin
            bus.h_data_bram_ena   <= 1'b1;
            bus.h_data_bram_wea   <= 1'b1;
            bus.h_data_bram_din   <= bus.s_data[H_DATA_WIDTH-1:0];
            bus.h_data_bram_addra <= {idx[H_DATA_ADDR_W-1:0], 2'b00};
          end
          if (cnt_h == '0 || (accept && last)) begin
            idx                   <= '0;
            h_data_bram_load_done <= 1'b1;
            state                 <= LD_NINFO;
          end else if (accept) begin
            idx <= idx + IDX_W'(1);
          end
        end
        LD_NINFO: begin
          if (accept && cnt_n != '0) begin
            bus.h_node_info_bram_ena   <= 1'b1;
            bus.h_node_info_bram_wea   <= 1'b1;
            bus.h_node_info_bram_din   <= bus.s_data[NODE_INFO_WIDTH-1:0];
            bus.h_node_info_bram_addra <= {idx[NODE_INFO_ADDR_W-1:0], 2'b00};
          end
          if (cnt_n == '0 || (accept && last)) begin
            idx                        <= '0;
            h_node_info_bram_load_done <= 1'b1;
            state                      <= LD_WGT;
          end else if (accept) begin
            idx <= idx + IDX_W'(1);
          end
        end
        LD_WGT: begin
          if (accept && cnt_w != '0) begin
            bus.wgt_bram_ena   <= 1'b1;
            bus.wgt_bram_wea   <= 1'b1;
            bus.wgt_bram_din   <= bus.s_data[DATA_WIDTH-1:0];
            bus.wgt_bram_addra <= {idx[WEIGHT_ADDR_W-1:0], 2'b00};
          end
          if (cnt_w == '0 || (accept && last)) begin
            idx                <= '0;
            wgt_bram_load_done <= 1'b1;
            busy               <= 1'b0;
            bus.s_ready        <= 1'b0;
            state              <= DONE;
          end else if (accept) begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GAT_LOADER_ERR_CHK_EN
  logic over;

  always_comb begin
    over = 1'b0;
    case (state)
      LD_HDATA: over = (bus.s_data >> H_DATA_WIDTH) != 32'd0;
      LD_NINFO: over = (bus.s_data >> NODE_INFO_WIDTH) != 32'd0;
      LD_WGT:   over = (bus.s_data >> DATA_WIDTH) != 32'd0;
      default:  over = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if (start && (state == IDLE || state == DONE))
      err <= 1'b0;
    else if (accept && over)
      err <= 1'b1;
  end
`else
  logic unused_hi_bits;
  assign unused_hi_bits = ^bus.s_data;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_gat_bram_loader.sv
// tb/tb_gat_bram_loader.sv - Directed self-checking bench for gat_bram_loader
module tb_gat_bram_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] h_data_cnt;
  logic [14:0] h_node_info_cnt;
  logic [15:0] wgt_cnt;
  logic        h_done, n_done, w_done, busy, err;
  int          vectors = 0;
  int          miscompares = 0;
  int          h_wr = 0, n_wr = 0, w_wr = 0;
  int          h_snap, w_snap;

`ifdef GAT_LOADER_ERR_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int         sec_t[9] = '{0, 0, 0, 1, 1, 2, 2, 2, 2};
  int         adr_t[9] = '{0, 4, 8, 0, 4, 0, 4, 8, 12};
  logic [2:0] dn_t[9]  = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b011,
                           3'b011, 3'b011, 3'b011, 3'b111};

  gat_bram_loader_if bus ();

  gat_bram_loader dut (
    .clk                        (clk),
    .rst                        (rst),
    .start                      (start),
    .h_data_cnt                 (h_data_cnt),
    .h_node_info_cnt            (h_node_info_cnt),
    .wgt_cnt                    (wgt_cnt),
    .bus                        (bus),
    .h_data_bram_load_done      (h_done),
    .h_node_info_bram_load_done (n_done),
    .wgt_bram_load_done         (w_done),
    .busy                       (busy),
    .err                        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.h_data_bram_ena)      h_wr++;
    if (bus.h_node_info_bram_ena) n_wr++;
    if (bus.wgt_bram_ena)         w_wr++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic no_strobe(input string tag);
    chk({tag, "_h_ena"}, 32'(bus.h_data_bram_ena), 0);
    chk({tag, "_n_ena"}, 32'(bus.h_node_info_bram_ena), 0);
    chk({tag, "_w_ena"}, 32'(bus.wgt_bram_ena), 0);
  endtask

  task automatic do_start(input logic [18:0] h, input logic [14:0] n, input logic [15:0] w);
    h_data_cnt = h; h_node_info_cnt = n; wgt_cnt = w;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input int sec, input int addr, input logic [31:0] d, input logic [2:0] dn);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    step();
    chk("h_ena", 32'(bus.h_data_bram_ena), 32'(sec == 0));
    chk("n_ena", 32'(bus.h_node_info_bram_ena), 32'(sec == 1));
    chk("w_ena", 32'(bus.wgt_bram_ena), 32'(sec == 2));
    case (sec)
      0: begin
        chk("h_wea", 32'(bus.h_data_bram_wea), 1);
        chk("h_din", 32'(bus.h_data_bram_din), d);
        chk("h_addra", 32'(bus.h_data_bram_addra), 32'(addr));
      end
      1: begin
        chk("n_wea", 32'(bus.h_node_info_bram_wea), 1);
        chk("n_din", 32'(bus.h_node_info_bram_din), d);
        chk("n_addra", 32'(bus.h_node_info_bram_addra), 32'(addr));
      end
      default: begin
        chk("w_wea", 32'(bus.wgt_bram_wea), 1);
        chk("w_din", 32'(bus.wgt_bram_din), d);
        chk("w_addra", 32'(bus.wgt_bram_addra), 32'(addr));
      end
    endcase
    chk("h_done", 32'(h_done), 32'(dn[0]));
    chk("n_done", 32'(n_done), 32'(dn[1]));
    chk("w_done", 32'(w_done), 32'(dn[2]));
  endtask

  task automatic gap();
    bus.s_valid = 1'b0;
    step();
    no_strobe("gap");
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_dones"}, {29'd0, w_done, n_done, h_done}, 0);
    no_strobe(tag);
    chk({tag, "_h_addra"}, 32'(bus.h_data_bram_addra), 0);
    chk({tag, "_h_din"}, 32'(bus.h_data_bram_din), 0);
    chk({tag, "_n_addra"}, 32'(bus.h_node_info_bram_addra), 0);
    chk({tag, "_w_din"}, 32'(bus.wgt_bram_din), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    h_data_cnt = '0; h_node_info_cnt = '0; wgt_cnt = '0;
    step();
    step();
    reset_state("rst");
    rst = 1'b0;

    // Counts 3/2/4, continuous valid
    do_start(3, 2, 4);
    chk("a_busy", 32'(busy), 1);
    chk("a_s_ready", 32'(bus.s_ready), 1);
    for (int i = 0; i < 9; i++) beat(sec_t[i], adr_t[i], 32'(i * 17 + 1), dn_t[i]);
    bus.s_valid = 1'b0;
    chk("a_busy_done", 32'(busy), 0);
    chk("a_s_ready_done", 32'(bus.s_ready), 0);
    chk("a_err", 32'(err), 0);
    step();
    no_strobe("a_after");
    chk("a_dones_hold", {29'd0, w_done, n_done, h_done}, 32'h7);

    // Same load with valid pattern 1,0,0
    do_start(3, 2, 4);
    chk("b_dones_clr", {29'd0, w_done, n_done, h_done}, 0);
    for (int i = 0; i < 9; i++) begin
      beat(sec_t[i], adr_t[i], 32'(i * 17 + 65), dn_t[i]);
      gap();
      gap();
    end
    chk("b_busy", 32'(busy), 0);

    // Reset after 5 of 9 beats, then full reload
    do_start(3, 2, 4);
    for (int i = 0; i < 5; i++) beat(sec_t[i], adr_t[i], 32'(i * 3 + 7), dn_t[i]);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    reset_state("c_rst");
    do_start(3, 2, 4);
    chk("c_dones_clr", {29'd0, w_done, n_done, h_done}, 0);
    for (int i = 0; i < 9; i++) beat(sec_t[i], adr_t[i], 32'(200 - i), dn_t[i]);
    bus.s_valid = 1'b0;
    step();

    // start during LD_NINFO is ignored
    do_start(3, 2, 4);
    for (int i = 0; i < 4; i++) beat(sec_t[i], adr_t[i], 32'(i + 90), dn_t[i]);
    bus.s_valid = 1'b0;
    do_start(1, 1, 1);
    chk("d_busy", 32'(busy), 1);
    chk("d_h_done_kept", 32'(h_done), 1);
    chk("d_n_done", 32'(n_done), 0);
    no_strobe("d_ign");
    for (int i = 4; i < 9; i++) beat(sec_t[i], adr_t[i], 32'(i + 90), dn_t[i]);
    bus.s_valid = 1'b0;
    step();

    // Counts 0/1/0
    h_snap = h_wr; w_snap = w_wr;
    do_start(0, 1, 0);
    chk("e_h_done0", 32'(h_done), 0);
    step();
    chk("e_h_done1", 32'(h_done), 1);
    chk("e_n_done0", 32'(n_done), 0);
    no_strobe("e_skip");
    beat(1, 0, 32'h0005_A5A5, 3'b011);
    bus.s_valid = 1'b0;
    step();
    chk("e_w_done", 32'(w_done), 1);
    chk("e_busy", 32'(busy), 0);
    chk("e_s_ready", 32'(bus.s_ready), 0);
    chk("e_h_strobes", 32'(h_wr - h_snap), 0);
    chk("e_w_strobes", 32'(w_wr - w_snap), 0);
    step();

    // Over-width H data word
    do_start(1, 0, 0);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'h0008_0001;
    step();
    bus.s_valid = 1'b0;
    chk("f_h_ena", 32'(bus.h_data_bram_ena), 1);
    chk("f_h_din", 32'(bus.h_data_bram_din), 32'h1);
    chk("f_err", 32'(err), 32'(ERR_EXP));
    step();
    step();
    chk("f_busy", 32'(busy), 0);
    chk("f_dones", {29'd0, w_done, n_done, h_done}, 32'h7);
    chk("f_err_hold", 32'(err), 32'(ERR_EXP));
    do_start(1, 1, 1);
    chk("f_err_clr", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
